// File: rtl/mem_master_pkg.sv
// mem_master_pkg: shared definitions for the mem_master sequencer.
//   MM_ADDR_W / MM_DATA_W / MM_LEN_W : default widths (4K x 16 memory, 1..8 beat bursts)
//   mm_state_e                       : sequencer FSM state encoding
package mem_master_pkg;

  localparam int MM_ADDR_W = 12;
  localparam int MM_DATA_W = 16;
  localparam int MM_LEN_W  = 3;

  typedef enum logic [1:0] {
    MM_IDLE  = 2'd0,
    MM_READ  = 2'd1,
    MM_WRITE = 2'd2
  } mm_state_e;

endpackage

// File: rtl/mem_master_rsp.sv
// mem_master_rsp: read response capture stage.
// Registers memory read data on the rising edge that ends each issued read
// beat, producing the client response stream one cycle after the beat.
//   clk_i        : clock (rising edge)
//   rst_i        : synchronous active-high reset
//   issue_i      : a read beat is on the memory bus this cycle (registered strobe)
//   last_i       : the beat on the bus is the final beat of its burst
//   mem_data_i   : memory read data (only meaningful while issue_i is high)
//   rsp_valid_o  : response word valid
//   rsp_data_o   : response word, held while rsp_valid_o is low
//   rsp_last_o   : response word is the last of its burst
module mem_master_rsp
  import mem_master_pkg::*;
#(
  parameter int DATA_W = MM_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_i,
  input  logic              last_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_last_o
);

  logic              vld_q;
  logic              last_q;
  logic [DATA_W-1:0] data_q;

  // Capture edge: the memory drove mem_data_i at the preceding falling edge.
  // Data is loaded only for issued beats so a floating bus is never captured.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= issue_i;
      last_q <= issue_i && last_i;
      if (issue_i) begin
        data_q <= mem_data_i;
      end
    end
  end

  assign rsp_valid_o = vld_q;
  assign rsp_data_o  = data_q;
  assign rsp_last_o  = last_q;

endmodule

// File: rtl/mem_master.sv
// mem_master: initiator-side sequencer for a 4K x 16 falling-edge synchronous
// memory. Accepts single-word writes and 1..8-word incrementing read bursts
// over a valid/ready handshake, drives registered memory strobes/address/data
// (sampled by the memory mid-cycle), and returns read data as a registered
// response stream two cycles after the accepting cycle.
//   CLK, RST                 : clock, synchronous active-high reset
//   REQ_Valid/REQ_Ready      : request handshake (accept on Valid && Ready)
//   REQ_Write                : 1 = single-word write, 0 = read burst
//   REQ_Addr/REQ_Len/REQ_Data: start address, burst length-1, write data
//   RSP_Valid/RSP_Data/RSP_Last : read response stream, no backpressure
//   MEM_Read/MEM_Write       : memory strobes (never both high)
//   MEM_Addr/MEM_Data_Out    : memory address and write data
//   MEM_Data_In              : memory read data (Z when the memory is idle)
module mem_master
  import mem_master_pkg::*;
#(
  parameter int ADDR_W = MM_ADDR_W,
  parameter int DATA_W = MM_DATA_W,
  parameter int LEN_W  = MM_LEN_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_Valid,
  output logic              REQ_Ready,
  input  logic              REQ_Write,
  input  logic [ADDR_W-1:0] REQ_Addr,
  input  logic [LEN_W-1:0]  REQ_Len,
  input  logic [DATA_W-1:0] REQ_Data,
  output logic              RSP_Valid,
  output logic [DATA_W-1:0] RSP_Data,
  output logic              RSP_Last,
  output logic              MEM_Read,
  output logic              MEM_Write,
  output logic [ADDR_W-1:0] MEM_Addr,
  output logic [DATA_W-1:0] MEM_Data_Out,
  input  logic [DATA_W-1:0] MEM_Data_In
);

  mm_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              req_fire;

  assign REQ_Ready = !RST && (state_q == MM_IDLE);
  assign req_fire  = REQ_Valid && REQ_Ready;

  // While in READ, addr_q/cnt_q describe the beat currently on the bus; the
  // beat carrying cnt_q == 0 is the last one and the FSM leaves READ after it.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MM_IDLE: begin
        if (req_fire) begin
          addr_d = REQ_Addr;
          if (REQ_Write) begin
            wdata_d = REQ_Data;
            state_d = MM_WRITE;
          end else begin
            cnt_d   = REQ_Len;
            state_d = MM_READ;
          end
        end
      end
      MM_READ: begin
        if (cnt_q == '0) begin
          state_d = MM_IDLE;
        end else begin
          // Natural ADDR_W-bit overflow gives the 4095 -> 0 wrap.
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
        end
      end
      MM_WRITE: begin
        state_d = MM_IDLE;
      end
      default: begin
        state_d = MM_IDLE;
      end
    endcase
    // Strobes are registered from the next state so they line up with the
    // registered address/data in the same cycle.
    rd_d = (state_d == MM_READ);
    wr_d = (state_d == MM_WRITE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= MM_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign MEM_Read     = rd_q;
  assign MEM_Write    = wr_q;
  assign MEM_Addr     = addr_q;
  assign MEM_Data_Out = wdata_q;

  mem_master_rsp #(
    .DATA_W (DATA_W)
  ) u_rsp (
    .clk_i       (CLK),
    .rst_i       (RST),
    .issue_i     (rd_q),
    .last_i      (cnt_q == '0),
    .mem_data_i  (MEM_Data_In),
    .rsp_valid_o (RSP_Valid),
    .rsp_data_o  (RSP_Data),
    .rsp_last_o  (RSP_Last)
  );

endmodule

// File: tb/tb_mem_master.sv
module tb_mem_master;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_Valid;
  logic        REQ_Ready;
  logic        REQ_Write;
  logic [11:0] REQ_Addr;
  logic [2:0]  REQ_Len;
  logic [15:0] REQ_Data;
  logic        RSP_Valid;
  logic [15:0] RSP_Data;
  logic        RSP_Last;
  logic        MEM_Read;
  logic        MEM_Write;
  logic [11:0] MEM_Addr;
  logic [15:0] MEM_Data_Out;
  wire  [15:0] MEM_Data_In;

  mem_master dut (
    .CLK          (CLK),
    .RST          (RST),
    .REQ_Valid    (REQ_Valid),
    .REQ_Ready    (REQ_Ready),
    .REQ_Write    (REQ_Write),
    .REQ_Addr     (REQ_Addr),
    .REQ_Len      (REQ_Len),
    .REQ_Data     (REQ_Data),
    .RSP_Valid    (RSP_Valid),
    .RSP_Data     (RSP_Data),
    .RSP_Last     (RSP_Last),
    .MEM_Read     (MEM_Read),
    .MEM_Write    (MEM_Write),
    .MEM_Addr     (MEM_Addr),
    .MEM_Data_Out (MEM_Data_Out),
    .MEM_Data_In  (MEM_Data_In)
  );

  always #5 CLK = ~CLK;

  // Falling-edge synchronous 4K x 16 memory; drives Z unless reading.
  logic [15:0] mem [4096];
  logic [15:0] mem_rd = 16'h0;
  logic        mem_drv = 1'b0;
  always @(negedge CLK) begin
    if (MEM_Write) mem[MEM_Addr] <= MEM_Data_Out;
    if (MEM_Read) mem_rd <= mem[MEM_Addr];
    mem_drv <= MEM_Read;
  end
  assign MEM_Data_In = mem_drv ? mem_rd : 16'hzzzz;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } rsp_t;

  rsp_t        exp_rsp_q [$];
  logic [11:0] exp_addr_q [$];
  logic [15:0] ref_mem [4096];
  logic [15:0] last_rsp = 16'h0;
  logic        mon_en = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: memory-bus read addresses and response words.
  always @(negedge CLK) begin
    rsp_t e;
    if (mon_en) begin
      if (MEM_Read) begin
        if (exp_addr_q.size() == 0) chk("mem_read_unexpected", 32'(MEM_Read), 0);
        else chk("mem_addr", 32'(MEM_Addr), 32'(exp_addr_q.pop_front()));
      end
      if (RSP_Valid) begin
        if (exp_rsp_q.size() == 0) chk("rsp_unexpected", 32'(RSP_Valid), 0);
        else begin
          e = exp_rsp_q.pop_front();
          chk("rsp_data", 32'(RSP_Data), 32'(e.d));
          chk("rsp_last", 32'(RSP_Last), 32'(e.l));
          last_rsp = e.d;
        end
      end
      chk("rd_wr_overlap", 32'(MEM_Read && MEM_Write), 0);
    end
  end

  task automatic nxt;
    @(posedge CLK);
    #1;
  endtask

  // Present a request, wait for acceptance, return one cycle after the
  // accepting edge with REQ_Valid still high.
  task automatic send(input logic wr, input logic [11:0] a, input logic [2:0] len,
                      input logic [15:0] d, output int waits, output logic rsp_at_acc);
    logic acc;
    REQ_Write = wr;
    REQ_Addr  = a;
    REQ_Len   = len;
    REQ_Data  = d;
    REQ_Valid = 1'b1;
    waits = 0;
    acc = 1'b0;
    rsp_at_acc = 1'b0;
    while (!acc && waits < 50) begin
      @(negedge CLK);
      waits++;
      acc = REQ_Ready;
      rsp_at_acc = RSP_Valid;
      nxt();
    end
    chk("accept_timeout", 32'(acc), 1);
    if (wr) begin
      ref_mem[a] = d;
    end else begin
      for (int i = 0; i <= int'(len); i++) begin
        exp_addr_q.push_back(a + 12'(i));
        exp_rsp_q.push_back('{d: ref_mem[a + 12'(i)], l: (i == int'(len))});
      end
    end
  endtask

  task automatic write1(input logic [11:0] a, input logic [15:0] d);
    int w;
    logic r;
    send(1'b1, a, 3'd0, d, w, r);
    REQ_Valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_rsp_q.size() != 0 || exp_addr_q.size() != 0) && n < 30) begin
      nxt();
      n++;
    end
    chk(tag, 32'(exp_rsp_q.size() + exp_addr_q.size()), 0);
  endtask

  initial begin
    int   w;
    logic r;
    logic [15:0] hold;
    RST = 1'b1;
    REQ_Valid = 1'b0;
    REQ_Write = 1'b0;
    REQ_Addr = '0;
    REQ_Len = '0;
    REQ_Data = '0;
    repeat (3) nxt();
    @(negedge CLK);
    chk("rst_ready", 32'(REQ_Ready), 0);
    chk("rst_mem_read", 32'(MEM_Read), 0);
    chk("rst_mem_write", 32'(MEM_Write), 0);
    chk("rst_mem_addr", 32'(MEM_Addr), 0);
    chk("rst_mem_dout", 32'(MEM_Data_Out), 0);
    chk("rst_rsp_valid", 32'(RSP_Valid), 0);
    chk("rst_rsp_data", 32'(RSP_Data), 0);
    chk("rst_rsp_last", 32'(RSP_Last), 0);
    nxt();
    RST = 1'b0;
    mon_en = 1'b1;
    @(negedge CLK);
    chk("ready_after_rst", 32'(REQ_Ready), 1);
    nxt();

    // Write then read back one word.
    write1(12'h010, 16'h1234);
    @(negedge CLK);
    chk("wr_strobe", 32'(MEM_Write), 1);
    chk("wr_addr", 32'(MEM_Addr), 32'h010);
    chk("wr_data", 32'(MEM_Data_Out), 32'h1234);
    chk("wr_no_read", 32'(MEM_Read), 0);
    chk("wr_ready_low", 32'(REQ_Ready), 0);
    nxt();
    @(negedge CLK);
    chk("wr_one_cycle", 32'(MEM_Write), 0);
    chk("wr_ready_back", 32'(REQ_Ready), 1);
    nxt();
    send(1'b0, 12'h010, 3'd0, 16'h0, w, r);
    REQ_Valid = 1'b0;
    @(negedge CLK);
    chk("rd_lat_early", 32'(RSP_Valid), 0);
    nxt();
    @(negedge CLK);
    chk("rd_lat", 32'(RSP_Valid), 1);
    chk("rd_single_last", 32'(RSP_Last), 1);
    chk("rd_ready_back", 32'(REQ_Ready), 1);
    nxt();
    drain("drain_single");

    // 8-beat burst over preloaded words.
    for (int i = 0; i < 8; i++) write1(12'h100 + 12'(i), 16'hA000 + 16'(i));
    send(1'b0, 12'h100, 3'd7, 16'h0, w, r);
    REQ_Valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk("burst_ready_low", 32'(REQ_Ready), 0);
      chk("burst_rsp_contig", 32'(RSP_Valid), 32'(k != 0));
      nxt();
    end
    @(negedge CLK);
    chk("burst_ready_back", 32'(REQ_Ready), 1);
    chk("burst_final_rsp", 32'(RSP_Valid), 1);
    nxt();
    drain("drain_burst");

    // Address wrap 0xFFE -> 0x001.
    write1(12'hFFE, 16'h5E01);
    write1(12'hFFF, 16'h5E02);
    write1(12'h000, 16'h5E03);
    write1(12'h001, 16'h5E04);
    send(1'b0, 12'hFFE, 3'd3, 16'h0, w, r);
    REQ_Valid = 1'b0;
    drain("drain_wrap");

    // Back-to-back: 2-beat read with REQ_Valid held, then a write.
    write1(12'h020, 16'h1111);
    write1(12'h021, 16'h2222);
    send(1'b0, 12'h020, 3'd1, 16'h0, w, r);
    send(1'b1, 12'h021, 3'd0, 16'hBEEF, w, r);
    REQ_Valid = 1'b0;
    chk("b2b_accept_wait", 32'(w), 3);
    chk("b2b_last_rsp_overlap", 32'(r), 1);
    @(negedge CLK);
    chk("b2b_wr_strobe", 32'(MEM_Write), 1);
    chk("b2b_wr_addr", 32'(MEM_Addr), 32'h021);
    chk("b2b_wr_data", 32'(MEM_Data_Out), 32'hBEEF);
    nxt();
    drain("drain_b2b");
    send(1'b0, 12'h021, 3'd0, 16'h0, w, r);
    REQ_Valid = 1'b0;
    drain("drain_b2b_readback");

    // Idle bus: memory floats, response stream must stay quiet and hold.
    hold = last_rsp;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      chk("idle_rsp_valid", 32'(RSP_Valid), 0);
      chk("idle_rsp_hold", 32'(RSP_Data), 32'(hold));
      nxt();
    end

    // Reset on the 3rd beat of an 8-beat burst.
    write1(12'h040, 16'h7001);
    write1(12'h041, 16'h7002);
    write1(12'h042, 16'h7003);
    send(1'b0, 12'h040, 3'd7, 16'h0, w, r);
    REQ_Valid = 1'b0;
    nxt();
    nxt();
    RST = 1'b1;
    nxt();
    RST = 1'b0;
    @(negedge CLK);
    chk("rstmid_beats_issued", 32'(exp_addr_q.size()), 5);
    chk("rstmid_rsp_seen", 32'(exp_rsp_q.size()), 6);
    exp_addr_q.delete();
    exp_rsp_q.delete();
    chk("rstmid_mem_read", 32'(MEM_Read), 0);
    chk("rstmid_mem_addr", 32'(MEM_Addr), 0);
    chk("rstmid_mem_dout", 32'(MEM_Data_Out), 0);
    chk("rstmid_rsp_valid", 32'(RSP_Valid), 0);
    chk("rstmid_rsp_data", 32'(RSP_Data), 0);
    chk("rstmid_rsp_last", 32'(RSP_Last), 0);
    chk("rstmid_ready", 32'(REQ_Ready), 1);
    for (int k = 0; k < 6; k++) begin
      nxt();
      @(negedge CLK);
      chk("rstmid_quiet", 32'(RSP_Valid || MEM_Read), 0);
    end
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
